// File: rtl/perf_pkg.sv
// Shared types and constants for the commit-side performance monitor:
// counter indices, trace entry layout and register-select codes.
package perf_pkg;

    typedef enum logic [1:0] {
        CNT_CYC     = 2'd0,
        CNT_INSTRET = 2'd1,
        CNT_CTRL    = 2'd2,
        CNT_MIS     = 2'd3
    } cnt_idx_e;

    localparam int NUM_CNT = 4;

    typedef struct packed {
        logic        mis;
        logic [31:0] pc;
    } trace_entry_t;

    localparam logic [2:0] SEL_CYC_LO     = 3'd0;
    localparam logic [2:0] SEL_CYC_HI     = 3'd1;
    localparam logic [2:0] SEL_INSTRET_LO = 3'd2;
    localparam logic [2:0] SEL_INSTRET_HI = 3'd3;
    localparam logic [2:0] SEL_CTRL_LO    = 3'd4;
    localparam logic [2:0] SEL_CTRL_HI    = 3'd5;
    localparam logic [2:0] SEL_MIS_LO     = 3'd6;
    localparam logic [2:0] SEL_MIS_HI     = 3'd7;

    function automatic cnt_idx_e sel_to_idx(input logic [2:0] sel);
        case (sel)
            SEL_CYC_LO,     SEL_CYC_HI:     return CNT_CYC;
            SEL_INSTRET_LO, SEL_INSTRET_HI: return CNT_INSTRET;
            SEL_CTRL_LO,    SEL_CTRL_HI:    return CNT_CTRL;
            SEL_MIS_LO,     SEL_MIS_HI:     return CNT_MIS;
            default:                        return CNT_CYC;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO with sticky overflow flag; a push on a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 33
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic                     o_vld,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic              ovf;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_FULL);
    assign do_pop  = i_pop & (cnt != '0);
    assign do_push = i_push & (~full | do_pop);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (i_push & full & ~do_pop) ovf <= 1'b1;
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

    assign o_vld  = (cnt != '0);
    assign o_data = o_vld ? mem[rd_ptr] : '0;
    assign o_cnt  = cnt;
    assign o_ovf  = ovf;

endmodule

// File: rtl/perf_monitor.sv
// Commit-side performance monitor: 64-bit event counters with coherent
// lo/hi reads, mispredict re-alignment and a trace FIFO of control transfers.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int TRACE_DEPTH = 8,
    parameter int MISPRED_LAG = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_insn_vld,
    input  logic                           i_ctrl,
    input  logic [31:0]                    i_pc_debug,
    input  logic                           i_mispred,
    input  logic                           i_clear,
    input  logic                           i_freeze,
    input  logic [2:0]                     i_cnt_sel,
    output logic [31:0]                    o_rd_data,
    output logic                           o_trace_vld,
    output logic [31:0]                    o_trace_pc,
    output logic                           o_trace_mis,
    input  logic                           i_trace_pop,
    output logic [$clog2(TRACE_DEPTH):0]   o_trace_cnt,
    output logic                           o_trace_ovf
);
    logic [MISPRED_LAG-1:0] mis_p;
    logic                   mis_al;
    logic [63:0]            cyc_q;
    logic [63:0]            instret_q;
    logic [63:0]            ctrl_q;
    logic [63:0]            mis_q;
    logic [63:0]            cnt_vec [NUM_CNT];
    logic [31:0]            shadow_q [NUM_CNT];
    logic [31:0]            rd_data_q;
    cnt_idx_e               sel_idx;
    logic                   sel_hi;
    logic                   trace_push;
    trace_entry_t           push_entry;
    trace_entry_t           head_entry;

    // Execute-stage mispredict delayed to line up with its writeback commit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mis_p <= '0;
        end else begin
            mis_p[0] <= i_mispred;
            for (int i = 1; i < MISPRED_LAG; i++) mis_p[i] <= mis_p[i-1];
        end
    end

    assign mis_al = mis_p[MISPRED_LAG-1];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cyc_q     <= '0;
            instret_q <= '0;
            ctrl_q    <= '0;
            mis_q     <= '0;
        end else if (i_clear) begin
            cyc_q     <= '0;
            instret_q <= '0;
            ctrl_q    <= '0;
            mis_q     <= '0;
        end else if (!i_freeze) begin
            cyc_q <= cyc_q + 64'd1;
            if (i_insn_vld)          instret_q <= instret_q + 64'd1;
            if (i_insn_vld & i_ctrl) ctrl_q    <= ctrl_q + 64'd1;
            if (mis_al)              mis_q     <= mis_q + 64'd1;
        end
    end

    always_comb begin
        cnt_vec[CNT_CYC]     = cyc_q;
        cnt_vec[CNT_INSTRET] = instret_q;
        cnt_vec[CNT_CTRL]    = ctrl_q;
        cnt_vec[CNT_MIS]     = mis_q;
        sel_idx              = sel_to_idx(i_cnt_sel);
        sel_hi               = i_cnt_sel[0];
    end

    // A lo read snapshots the hi half so a following hi read is carry-coherent.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_data_q <= '0;
            for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
        end else if (sel_hi) begin
            rd_data_q <= shadow_q[sel_idx];
        end else begin
            rd_data_q         <= cnt_vec[sel_idx][31:0];
            shadow_q[sel_idx] <= cnt_vec[sel_idx][63:32];
        end
    end

    assign o_rd_data  = rd_data_q;
    assign trace_push = i_insn_vld & i_ctrl & ~i_freeze & ~i_clear;
    assign push_entry = '{mis: mis_al, pc: i_pc_debug};

    trace_fifo #(
        .DEPTH  (TRACE_DEPTH),
        .DATA_W ($bits(trace_entry_t))
    ) u_trace_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_clear),
        .i_push  (trace_push),
        .i_data  (push_entry),
        .i_pop   (i_trace_pop),
        .o_vld   (o_trace_vld),
        .o_data  (head_entry),
        .o_cnt   (o_trace_cnt),
        .o_ovf   (o_trace_ovf)
    );

    assign o_trace_pc  = head_entry.pc;
    assign o_trace_mis = head_entry.mis;

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: directed stimulus queues expected read
// words and trace entries; a negedge monitor pops and compares them.
module tb_perf_monitor;
    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_insn_vld = 1'b0;
    logic        i_ctrl = 1'b0;
    logic [31:0] i_pc_debug = '0;
    logic        i_mispred = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_freeze = 1'b0;
    logic [2:0]  i_cnt_sel = '0;
    logic        i_trace_pop = 1'b0;
    logic [31:0] o_rd_data;
    logic        o_trace_vld;
    logic [31:0] o_trace_pc;
    logic        o_trace_mis;
    logic [3:0]  o_trace_cnt;
    logic        o_trace_ovf;

    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_q[$];
    logic [32:0] trace_q[$];
    int          checks = 0;
    int          errors = 0;

    perf_monitor #(.TRACE_DEPTH(8), .MISPRED_LAG(2)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_insn_vld  (i_insn_vld),
        .i_ctrl      (i_ctrl),
        .i_pc_debug  (i_pc_debug),
        .i_mispred   (i_mispred),
        .i_clear     (i_clear),
        .i_freeze    (i_freeze),
        .i_cnt_sel   (i_cnt_sel),
        .o_rd_data   (o_rd_data),
        .o_trace_vld (o_trace_vld),
        .o_trace_pc  (o_trace_pc),
        .o_trace_mis (o_trace_mis),
        .i_trace_pop (i_trace_pop),
        .o_trace_cnt (o_trace_cnt),
        .o_trace_ovf (o_trace_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] exp);
        i_cnt_sel = sel;
        rd_req    = 1'b1;
        rd_q.push_back(exp);
        step();
        rd_req = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic mis_pulse);
        i_insn_vld = 1'b1;
        i_ctrl     = 1'b1;
        i_pc_debug = pc;
        i_mispred  = mis_pulse;
        step();
        i_insn_vld = 1'b0;
        i_ctrl     = 1'b0;
        i_mispred  = 1'b0;
    endtask

    // Monitor: read words appear one edge after the select; trace heads on pop.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_scoreboard: got read %0h, expected none queued", o_rd_data);
            end else begin
                check("rd_data", {32'h0, o_rd_data}, {32'h0, rd_q.pop_front()});
            end
        end
        rd_pend <= rd_req;
        if (i_trace_pop && o_trace_vld) begin
            if (trace_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trace_scoreboard: got entry %0h, expected none queued", o_trace_pc);
            end else begin
                check("trace_head", {31'h0, o_trace_mis, o_trace_pc}, {31'h0, trace_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held three cycles
        repeat (3) step();
        check("rst_rd_data", o_rd_data, 0);
        check("rst_vld", o_trace_vld, 0);
        check("rst_pc", o_trace_pc, 0);
        check("rst_mis", o_trace_mis, 0);
        check("rst_cnt", o_trace_cnt, 0);
        check("rst_ovf", o_trace_ovf, 0);
        i_reset = 1'b1;
        repeat (10) step();
        rd(3'd0, 32'd10);
        rd(3'd1, 32'd0);
        check("idle_vld", o_trace_vld, 0);
        check("idle_cnt", o_trace_cnt, 0);
        check("idle_ovf", o_trace_ovf, 0);

        // Five control commits, mispredict aligned onto 0x18
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            trace_q.push_back({(k == 2), 32'h10 + 32'(4 * k)});
            commit(32'h10 + 32'(4 * k), (k == 0));
        end
        i_freeze = 1'b1;
        check("five_cnt", o_trace_cnt, 5);
        rd(3'd0, 32'd5);
        rd(3'd1, 32'd0);
        rd(3'd2, 32'd5);
        rd(3'd3, 32'd0);
        rd(3'd4, 32'd5);
        rd(3'd5, 32'd0);
        rd(3'd6, 32'd1);
        rd(3'd7, 32'd0);
        i_trace_pop = 1'b1;
        repeat (5) step();
        i_trace_pop = 1'b0;
        check("drain_vld", o_trace_vld, 0);
        check("drain_cnt", o_trace_cnt, 0);
        i_freeze = 1'b0;

        // Fill, push+pop on full, then overflow
        for (int k = 0; k < 8; k++) begin
            trace_q.push_back({1'b0, 32'h100 + 32'(4 * k)});
            commit(32'h100 + 32'(4 * k), 1'b0);
        end
        check("full_cnt", o_trace_cnt, 8);
        check("full_ovf", o_trace_ovf, 0);
        check("full_vld", o_trace_vld, 1);
        i_trace_pop = 1'b1;
        trace_q.push_back({1'b0, 32'h120});
        commit(32'h120, 1'b0);
        i_trace_pop = 1'b0;
        check("pushpop_cnt", o_trace_cnt, 8);
        check("pushpop_ovf", o_trace_ovf, 0);
        commit(32'h124, 1'b0);
        commit(32'h128, 1'b0);
        check("ovf_cnt", o_trace_cnt, 8);
        check("ovf_flag", o_trace_ovf, 1);
        check("ovf_head", o_trace_pc, 32'h104);
        i_trace_pop = 1'b1;
        repeat (8) step();
        i_trace_pop = 1'b0;
        check("ovf_drain_vld", o_trace_vld, 0);
        check("ovf_sticky", o_trace_ovf, 1);

        // Coherent read across the 32-bit carry
        force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cyc_q;
        rd(3'd0, 32'hFFFF_FFFF);
        rd(3'd1, 32'h0);
        rd(3'd0, 32'h1);
        rd(3'd1, 32'h1);

        // Freeze with commits, then clear colliding with a commit
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clr_ovf", o_trace_ovf, 0);
        check("clr_cnt", o_trace_cnt, 0);
        i_freeze = 1'b1;
        i_insn_vld = 1'b1;
        i_ctrl = 1'b1;
        i_pc_debug = 32'h300;
        repeat (20) step();
        i_insn_vld = 1'b0;
        i_ctrl = 1'b0;
        check("frz_cnt", o_trace_cnt, 0);
        rd(3'd0, 32'd0);
        rd(3'd2, 32'd0);
        rd(3'd4, 32'd0);
        i_freeze = 1'b0;
        commit(32'h400, 1'b0);
        commit(32'h404, 1'b0);
        commit(32'h408, 1'b0);
        check("preclr_cnt", o_trace_cnt, 3);
        i_clear = 1'b1;
        commit(32'h40C, 1'b0);
        i_clear = 1'b0;
        check("clrcommit_cnt", o_trace_cnt, 0);
        check("clrcommit_vld", o_trace_vld, 0);
        rd(3'd0, 32'd0);
        rd(3'd2, 32'd0);
        rd(3'd4, 32'd0);
        rd(3'd6, 32'd0);
        rd(3'd0, 32'd4);

        // Asynchronous reset mid-burst
        i_cnt_sel = 3'd2;
        commit(32'h500, 1'b0);
        commit(32'h504, 1'b0);
        commit(32'h508, 1'b0);
        check("burst_cnt", o_trace_cnt, 3);
        #2;
        i_reset = 1'b0;
        #1;
        check("arst_vld", o_trace_vld, 0);
        check("arst_cnt", o_trace_cnt, 0);
        check("arst_rd_data", o_rd_data, 0);
        check("arst_cyc", dut.cyc_q, 0);
        check("arst_instret", dut.instret_q, 0);
        check("arst_ctrl", dut.ctrl_q, 0);
        step();
        i_reset = 1'b1;
        step();
        rd(3'd0, 32'd1);
        step();

        check("rd_q_empty", rd_q.size(), 0);
        check("trace_q_empty", trace_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Commit-side performance and trace monitor that sits directly downstream of the pipelined core's writeback/debug outputs. It counts cycles, retired instructions, control transfers and mispredictions, and records the PCs of retired control-transfer instructions in a small trace FIFO. Counters and trace are read over a simple register-select interface and exposed to software or test benches. The block re-aligns the core's execute-stage mispredict pulse with the writeback-stage commit it belongs to.

## Interface
- TRACE_DEPTH, 8: trace FIFO entries; power of two, minimum 2.
- MISPRED_LAG, 2: cycles between the core's mispredict pulse and the writeback-stage commit of the same instruction.
- i_clk  in  1  global clock, rising edge.
- i_reset  in  1  global reset, asynchronous, active-low.
- i_insn_vld  in  1  core writeback instruction valid.
- i_ctrl  in  1  writeback instruction is a branch or jump.
- i_pc_debug  in  32  writeback PC.
- i_mispred  in  1  core mispredict pulse, execute-stage timing.
- i_clear  in  1  synchronous clear of counters, trace and overflow flag.
- i_freeze  in  1  hold all counters; block trace pushes.
- i_cnt_sel  in  3  counter word select, see Operation.
- o_rd_data  out  32  selected counter word, registered.
- o_trace_vld  out  1  trace FIFO non-empty.
- o_trace_pc  out  32  PC at FIFO head.
- o_trace_mis  out  1  head entry was mispredicted.
- i_trace_pop  in  1  consume head entry; ignored when o_trace_vld=0.
- o_trace_cnt  out  $clog2(TRACE_DEPTH)+1  current occupancy.
- o_trace_ovf  out  1  sticky: a push was dropped because the FIFO was full.

## Operation
- Alignment: i_mispred passes through a MISPRED_LAG-stage shift register. Its output is mis_al. i_clear does not affect the shift register.
- Counters are 64-bit and wrap modulo 2^64:
  - CYC increments every cycle.
  - INSTRET increments on i_insn_vld.
  - CTRL increments on i_insn_vld & i_ctrl.
  - MIS increments on mis_al.
- All counters hold while i_freeze=1.
- i_clear has priority over increment in the same cycle. The counter reads 0 in the next cycle.
- Select encoding:
  - 0/1 = CYC lo/hi
  - 2/3 = INSTRET lo/hi
  - 4/5 = CTRL lo/hi
  - 6/7 = MIS lo/hi
- Coherent read: selecting a lo word latches the matching hi word into a shadow register in the same edge. A following hi select returns the shadow, not the live value.
- o_rd_data = value at the sampling edge, one cycle after i_cnt_sel is presented.
- Trace push condition: i_insn_vld & i_ctrl & ~i_freeze & ~i_clear. Entry is {mis_al, i_pc_debug}.
- FIFO is first-word-fall-through: head is valid on o_trace_pc and o_trace_mis whenever o_trace_vld=1.
- Full plus push without pop: the entry is dropped, o_trace_ovf is set, and contents are unchanged.
- Full plus push plus pop: both occur, occupancy is unchanged, and no overflow is flagged.
- Empty plus push plus pop: the pop is ignored and the push occurs.
- Pointers wrap modulo TRACE_DEPTH.
- i_clear empties the FIFO (pointers and count go to 0) and clears o_trace_ovf.

## Timing
- Reset values: all counters, shadows and the delay line are 0. o_rd_data=0, o_trace_vld=0, o_trace_pc=0, o_trace_mis=0, o_trace_cnt=0, o_trace_ovf=0.
- Reset asserted mid-operation clears everything asynchronously. Operation resumes on the first edge after deassertion, with CYC=1 after that edge.
- Commit to counter visibility: counters update on the edge that samples the commit. The new value appears on o_rd_data one further edge later.
- Push to o_trace_vld: 1 cycle. Pop to next head: 1 cycle.
- Mispredict latency: i_mispred at edge t contributes to MIS and to the trace entry committed at edge t+MISPRED_LAG.

## Structure
- The shared package perf_pkg holds:
  - the counter-index enum (CYC, INSTRET, CTRL, MIS);
  - the trace entry struct {mis, pc[31:0]};
  - the select-code constants.
- One sub-module, trace_fifo, parameterised by depth and entry width. It contains the pointers, count and overflow flag.
- The counters, delay line, shadow registers and read mux live in the top level.

## Test plan
- Reset held 3 cycles then released; idle 10 cycles, then select 0 → o_rd_data=10 with CYC counting from 1 after release. All other outputs remain 0.
- 5 commits with i_ctrl=1 at PCs 0x10,0x14,0x18,0x1C,0x20; i_mispred pulsed 2 cycles before the 0x18 commit → CTRL=5, MIS=1, and pops return the PCs in order with mis=1 only on 0x18.
- 10 control commits with no pops, TRACE_DEPTH=8 → o_trace_cnt=8, o_trace_ovf=1, and the head is the first PC. A push+pop on a full FIFO keeps cnt=8 and does not change ovf.
- Preload CYC=0x0000_0000_FFFF_FFFF; select 0 then 1 across the carry → the hi read returns the shadowed 0x0, not 0x1.
- i_freeze high for 20 cycles with commits → counters unchanged and no pushes. i_clear asserted together with a commit → all counters and o_trace_cnt read 0 next cycle.
- Async reset asserted mid-burst with 3 entries queued → o_trace_vld=0 and all counters 0 immediately, with no clock edge required.
